fixed_to_float_converter: RTL

Sequential converter that turns signed two's-complement fixed-point LLR samples from the channel quantiser into IEEE-754 single-precision words for the floating-point belief-propagation datapath. It sits upstream of the floating-point adder and supplies its 32-bit operands. Normalisation is iterative: one left shift per cycle under a small FSM. Input and output both use valid/ready handshakes, with one sample in flight at a time.

---
 rtl/fp32_pkg.sv | 20 ++
 rtl/fp32_field_packer.sv | 24 ++
 rtl/fixed_to_float_converter.sv | 110 +++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared float32 field definitions and converter FSM states.
package fp32_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exponent;
    logic [FP32_MAN_W-1:0] mantissa;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp32_field_packer.sv
// Packs sign, biased exponent and the bits below the leading one of a
// normalised magnitude into a float32 word.
module fp32_field_packer
  import fp32_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                  sign,
  input  logic [FP32_EXP_W-1:0] exp_in,
  input  logic [IN_WIDTH-2:0]   mag_frac,
  output logic [31:0]           word
);

  fp32_t fields;

  always_comb begin
    fields.sign     = sign;
    fields.exponent = exp_in;
    // Left-align below the hidden bit; the shift zero-pads on the right.
    fields.mantissa = FP32_MAN_W'(mag_frac) << (FP32_MAN_W + 1 - IN_WIDTH);
    word            = fields;
  end

endmodule

// File: rtl/fixed_to_float_converter.sv
// Signed fixed-point to float32 converter; normalises by one left shift per
// cycle, with valid/ready on both sides and one sample in flight.
module fixed_to_float_converter
  import fp32_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  if (IN_WIDTH < 2 || IN_WIDTH > 24) begin : g_bad_in_width
    $error("IN_WIDTH must be in 2..24");
  end
  if (FRAC_BITS < 0 || FRAC_BITS > 126) begin : g_bad_frac_bits
    $error("FRAC_BITS must be in 0..126");
  end

  localparam logic [FP32_EXP_W-1:0] EXP_INIT =
    FP32_EXP_W'(FP32_BIAS + IN_WIDTH - 1 - FRAC_BITS);

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   mag_q, mag_d;
  logic [FP32_EXP_W-1:0] exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic [31:0]           out_data_q, out_data_d;
  logic [31:0]           packed_word;

  fp32_field_packer #(
    .IN_WIDTH(IN_WIDTH)
  ) u_packer (
    .sign     (sign_q),
    .exp_in   (exp_q),
    .mag_frac (mag_q[IN_WIDTH-2:0]),
    .word     (packed_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[IN_WIDTH-1];
          mag_d   = in_data[IN_WIDTH-1] ? (~in_data + IN_WIDTH'(1)) : in_data;
          exp_d   = EXP_INIT;
          state_d = NORM;
        end
      end
      NORM: begin
        // A zero sample spends one cycle here so its latency matches lz=0.
        if (mag_q == '0) begin
          out_data_d = '0;
          state_d    = DONE;
        end else if (mag_q[IN_WIDTH-1]) begin
          out_data_d = packed_word;
          state_d    = DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - FP32_EXP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    out_data  = out_data_q;
  end

endmodule
